dcache: RTL and testbench
=========================

# dcache

Data cache on the memory-responder side of `datapath_cache_if`. It answers the pipelined datapath's `dmemREN`/`dmemWEN` requests with `dhit`/`dmemload` and initiates word transfers to the memory controller on cache misses. It is 2-way set-associative, 8 sets, 2-word blocks, write-back, write-allocate, with per-set LRU replacement. On `halt` it writes back every dirty block, then raises `flushed`.

## Interface
Parameters: none. Geometry is fixed by package constants.

Ports:
- `CLK  in  1`: clock, rising edge.
- `nRST  in  1`: reset, asynchronous, active-low.
- `halt  in  1`: datapath halt; starts the flush.
- `dmemREN  in  1`: load request.
- `dmemWEN  in  1`: store request.
- `dmemaddr  in  32`: byte address. Bits [1:0] are ignored.
- `dmemstore  in  32`: store data.
- `dhit  out  1`: request satisfied this cycle.
- `dmemload  out  32`: load data.
- `flushed  out  1`: flush complete; sticky until reset.
- `dREN  out  1`: memory read request.
- `dWEN  out  1`: memory write request.
- `daddr  out  32`: memory word address.
- `dstore  out  32`: memory write data.
- `dwait  in  1`: memory busy; a transfer completes in the cycle it is low.
- `dload  in  32`: memory read data.

The datapath-side ports are the `datapath_cache_if.cache` modport. The memory-side ports are the `caches_if.dcache` modport.

## Operation
- **Address split:** tag = [31:6] (26b), index = [5:3], block offset = [2], byte offset = [1:0].
- **Frame contents:** valid, dirty, tag, data[2]. There is one LRU bit per set, naming the least-recently-used way.
- **Hit:** a valid way whose tag matches. If both `dmemREN` and `dmemWEN` are high, WEN has priority.
- **IDLE state:**
  - Hit: `dhit`=1 combinationally.
  - Load hit: `dmemload` = the addressed word. Otherwise `dmemload`=0.
  - Store hit: word and dirty=1 are written at the clock edge.
  - Any hit: the set's LRU bit is set to the other way.
- **Victim choice:** the first invalid way (way 0 has priority), otherwise the LRU way.
- **Miss with dirty victim:** IDLE -> WB0 -> WB1 -> LD0 -> LD1 -> IDLE.
- **Miss with clean or invalid victim:** IDLE -> LD0 -> LD1 -> IDLE.
- **WBn:** `dWEN`=1, `daddr`={victim tag, index, n, 2'b00}, `dstore`=victim word n. Advances when `dwait`=0.
- **LDn:** `dREN`=1, `daddr`={req tag, index, n, 2'b00}. When `dwait`=0, `dload` is written into victim word n. On leaving LD1: valid=1, dirty=0, tag written.
- **Retry after refill:** the request is re-evaluated in IDLE and hits the following cycle.
- **Halt:** `halt` sampled in IDLE has priority over requests.
  - A 4-bit frame counter {set, way} walks 0..15.
  - FCHK: if the frame is valid and dirty, go to FWB0 -> FWB1 (same bus behaviour as WBn) and clear dirty. Otherwise increment the counter.
  - After frame 15, go to FDONE: `flushed`=1, no bus activity, requests ignored until reset.
- **dhit outside IDLE:** never asserted.

## Timing
- **Reset:** all outputs 0; all valid, dirty and LRU bits 0; state IDLE; counter 0.
- **Hit latency:** 0 cycles (same cycle as the request).
- **Clean miss:** hit 3 cycles after request when memory has zero wait (LD0, LD1, IDLE).
- **Dirty miss:** hit 5 cycles after request when memory has zero wait.
- **Memory requests:** `dREN`/`dWEN` are held stable with address and data until `dwait` falls, then drop or advance on that edge. They are never asserted together.
- **Request inputs during a miss:** the datapath holds them stable. The cache re-reads the address in LD states, not a latched copy.
- **halt during a miss:** the miss completes first; the flush starts from IDLE.
- **Reset mid-transfer:** returns to IDLE immediately; partial data is discarded.

## Structure
- **`cache_types_pkg`:** `dcachef_t` (tag/idx/blkoff/bytoff packed struct), `dcache_frame_t`, the state enum, and constants DTAG_W=26, DIDX_W=3, DSETS=8, DWAYS=2.
- **Top module:** holds the FSM, LRU array, and flush counter.
- **Sub-module `dcache_way`:** 8-entry frame storage with valid/dirty/tag/data write enables and a combinational tag compare. Instantiated twice.

## Test plan
- **Cold load then repeat:** load 0x100 with `dload`=0xDEADBEEF, zero wait -> LD0 `daddr`=0x100, LD1 `daddr`=0x104, `dhit` 3 cycles after request with `dmemload`=0xDEADBEEF. A repeat load of 0x100 hits in 0 cycles.
- **Store hit then eviction:** store 0xCAFEF00D to 0x100 (hit) -> no bus traffic, dirty=1. Loads to 0x140 then 0x180 (same set 0) -> the second load evicts way 0, WB `daddr`=0x100 with `dstore`=0xCAFEF00D, then 0x104, then refill.
- **LRU order:** fill set 3 with 0x018 and 0x058, load 0x018 again, then load 0x098 -> the way holding 0x058 is replaced.
- **dwait stretch:** `dwait` high for 4 cycles per word -> `dREN` and `daddr` held constant throughout, and the refilled data is correct.
- **Halt flush:** three dirty frames in sets 0, 2 and 7, assert `halt` -> exactly 6 memory writes in set/way order, then `flushed`=1 and held.
- **Reset mid-refill:** drop `nRST` during LD1 -> all outputs 0, and the next access to the same address misses.

Source files
------------

// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared data cache geometry, address split, frame layout and FSM states.
package cache_types_pkg;
  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DSETS  = 8;
  localparam int DWAYS  = 2;
  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    logic [1:0][31:0]  data;
  } dcache_frame_t;
  typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1, FDONE} dstate_t;
endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the data cache, DSETS frames with per-field write enables.
// Ports: CLK/nRST clock and async active-low reset; idx selects the frame for read
// and write; cmp_tag is both the compare tag and the tag written by wr_tag;
// wr_valid sets valid, wr_dirty writes dirty_in, wr_data writes data_in to word wr_blk;
// frame is the selected frame, hit is valid && tag match.
module dcache_way
  import cache_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DIDX_W-1:0] idx,
  input  logic [DTAG_W-1:0] cmp_tag,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic              wr_tag,
  input  logic              wr_data,
  input  logic              wr_blk,
  input  logic              dirty_in,
  input  logic [31:0]       data_in,
  output dcache_frame_t     frame,
  output logic              hit
);
  dcache_frame_t frames [DSETS];
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DSETS; i++) frames[i] <= '0;
    end else begin
      if (wr_valid) frames[idx].valid <= 1'b1;
      if (wr_dirty) frames[idx].dirty <= dirty_in;
      if (wr_tag) frames[idx].tag <= cmp_tag;
      if (wr_data) frames[idx].data[wr_blk] <= data_in;
    end
  end
  assign frame = frames[idx];
  assign hit = frame.valid && (frame.tag == cmp_tag);
endmodule

// File: rtl/dcache.sv
// dcache: 2-way, 8-set, 2-word-block write-back/write-allocate data cache with LRU and halt flush.
// Ports: CLK/nRST clock and async active-low reset; halt starts the flush;
// dmemREN/dmemWEN/dmemaddr/dmemstore datapath request, dhit/dmemload response,
// flushed sticky flush-done; dREN/dWEN/daddr/dstore memory request, dwait/dload memory response.
module dcache
  import cache_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  dcachef_t          a;
  dstate_t           st, st_n;
  logic [DSETS-1:0]  lru, lru_n;
  logic [3:0]        cnt, cnt_n;
  logic              vway, vway_n;
  logic [DIDX_W-1:0] idx;
  dcache_frame_t     f0, f1, vf, ff;
  logic              hit0, hit1, vict, sel, flushing, req;
  logic              wr_valid, wr_dirty, wr_tag, wr_data, wr_blk, dirty_in, wway;
  logic [31:0]       data_in;
  logic              unused_bytoff;
  assign a = dmemaddr;
  assign unused_bytoff = ^a.bytoff;
  assign req = dmemREN || dmemWEN;
  assign flushing = (st == FCHK) || (st == FWB0) || (st == FWB1);
  // During the flush the frame counter {set, way} owns the index lines.
  assign idx = flushing ? cnt[3:1] : a.idx;
  assign vict = !f0.valid ? 1'b0 : !f1.valid ? 1'b1 : lru[idx];
  // The victim is chosen in IDLE and latched so later states address the same way.
  assign sel = (st == IDLE) ? vict : vway;
  assign vf = sel ? f1 : f0;
  assign ff = cnt[0] ? f1 : f0;
  dcache_way way0 (
    .CLK(CLK), .nRST(nRST), .idx(idx), .cmp_tag(a.tag),
    .wr_valid(wr_valid && !wway), .wr_dirty(wr_dirty && !wway),
    .wr_tag(wr_tag && !wway), .wr_data(wr_data && !wway),
    .wr_blk(wr_blk), .dirty_in(dirty_in), .data_in(data_in),
    .frame(f0), .hit(hit0)
  );
  dcache_way way1 (
    .CLK(CLK), .nRST(nRST), .idx(idx), .cmp_tag(a.tag),
    .wr_valid(wr_valid && wway), .wr_dirty(wr_dirty && wway),
    .wr_tag(wr_tag && wway), .wr_data(wr_data && wway),
    .wr_blk(wr_blk), .dirty_in(dirty_in), .data_in(data_in),
    .frame(f1), .hit(hit1)
  );
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st <= IDLE;
      lru <= '0;
      cnt <= '0;
      vway <= 1'b0;
    end else begin
      st <= st_n;
      lru <= lru_n;
      cnt <= cnt_n;
      vway <= vway_n;
    end
  end
  always_comb begin
    st_n = st;
    lru_n = lru;
    cnt_n = cnt;
    vway_n = vway;
    dhit = 1'b0;
    dmemload = '0;
    flushed = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;
    wr_tag = 1'b0;
    wr_data = 1'b0;
    wr_blk = a.blkoff;
    dirty_in = 1'b0;
    wway = sel;
    data_in = dload;
    case (st)
      IDLE: begin
        if (halt) begin
          st_n = FCHK;
        end else if (req && (hit0 || hit1)) begin
          dhit = 1'b1;
          wway = hit1;
          lru_n[idx] = !hit1;
          if (dmemWEN) begin
            wr_data = 1'b1;
            wr_dirty = 1'b1;
            dirty_in = 1'b1;
            data_in = dmemstore;
          end else begin
            dmemload = hit1 ? f1.data[a.blkoff] : f0.data[a.blkoff];
          end
        end else if (req) begin
          vway_n = vict;
          st_n = (vf.valid && vf.dirty) ? WB0 : LD0;
        end
      end
      WB0, WB1: begin
        dWEN = 1'b1;
        wr_blk = (st == WB1);
        daddr = {vf.tag, idx, wr_blk, 2'b00};
        dstore = vf.data[wr_blk];
        if (!dwait) st_n = (st == WB0) ? WB1 : LD0;
      end
      LD0, LD1: begin
        dREN = 1'b1;
        wr_blk = (st == LD1);
        daddr = {a.tag, idx, wr_blk, 2'b00};
        if (!dwait) begin
          wr_data = 1'b1;
          // Closing the refill validates the frame, clears dirty and installs the tag.
          wr_valid = (st == LD1);
          wr_dirty = (st == LD1);
          wr_tag = (st == LD1);
          st_n = (st == LD1) ? IDLE : LD1;
        end
      end
      FCHK: begin
        if (ff.valid && ff.dirty) st_n = FWB0;
        else if (cnt == 4'hF) st_n = FDONE;
        else cnt_n = cnt + 4'd1;
      end
      FWB0, FWB1: begin
        dWEN = 1'b1;
        wr_blk = (st == FWB1);
        daddr = {ff.tag, idx, wr_blk, 2'b00};
        dstore = ff.data[wr_blk];
        if (!dwait) begin
          if (st == FWB0) begin
            st_n = FWB1;
          end else begin
            wway = cnt[0];
            wr_dirty = 1'b1;
            st_n = (cnt == 4'hF) ? FDONE : FCHK;
            cnt_n = cnt + 4'd1;
          end
        end
      end
      FDONE: flushed = 1'b1;
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache with a small word-addressed memory responder.
module tb_dcache;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;
  int          wait_n = 0;
  int          wcnt;
  logic [31:0] mem [256];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          total = 0;
  int          passed = 0;

  dcache dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  // Memory holds its own byte address plus 0xF0000000, except 0x100 = 0xDEADBEEF.
  assign dwait = (dREN || dWEN) && (wcnt < wait_n);
  assign dload = mem[daddr[9:2]];
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= (i == 64) ? 32'hDEADBEEF : 32'hF0000000 + 32'(i * 4);
    end else if (dREN || dWEN) begin
      if (wcnt < wait_n) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (dWEN) begin
          mem[daddr[9:2]] <= dstore;
          wa.push_back(daddr);
          wd.push_back(dstore);
        end
      end
    end
  end

  task automatic wait_hit(input int max, output int cyc);
    cyc = 0;
    #1;
    while (!dhit && cyc < max) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic load(input logic [31:0] addr, output int cyc, output logic [31:0] data);
    @(negedge CLK);
    dmemREN = 1'b1;
    dmemWEN = 1'b0;
    dmemaddr = addr;
    wait_hit(40, cyc);
    data = dmemload;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, output int cyc);
    @(negedge CLK);
    dmemREN = 1'b0;
    dmemWEN = 1'b1;
    dmemaddr = addr;
    dmemstore = data;
    wait_hit(40, cyc);
  endtask

  task automatic idle();
    @(negedge CLK);
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    total++; if ({dhit, dmemload, flushed, dREN, dWEN, daddr, dstore} !== '0) $display("FAIL reset_outputs got dhit=%b load=%h fl=%b ren=%b wen=%b addr=%h st=%h want all 0", dhit, dmemload, flushed, dREN, dWEN, daddr, dstore); else passed++;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_load();
    int c;
    logic [31:0] d;
    @(negedge CLK);
    dmemREN = 1'b1;
    dmemaddr = 32'h100;
    #1;
    total++; if (dhit !== 1'b0) $display("FAIL cold_miss_dhit got %b want 0", dhit); else passed++;
    @(negedge CLK); #1;
    total++; if ({dREN, dWEN, daddr} !== {2'b10, 32'h100}) $display("FAIL cold_ld0 got ren=%b wen=%b addr=%h want 1 0 00000100", dREN, dWEN, daddr); else passed++;
    @(negedge CLK); #1;
    total++; if ({dREN, daddr} !== {1'b1, 32'h104}) $display("FAIL cold_ld1 got ren=%b addr=%h want 1 00000104", dREN, daddr); else passed++;
    @(negedge CLK); #1;
    total++; if ({dhit, dmemload} !== {1'b1, 32'hDEADBEEF}) $display("FAIL cold_hit got dhit=%b load=%h want 1 deadbeef", dhit, dmemload); else passed++;
    load(32'h100, c, d);
    total++; if (c !== 0 || d !== 32'hDEADBEEF) $display("FAIL repeat_hit got cyc=%0d data=%h want 0 deadbeef", c, d); else passed++;
    idle();
  endtask

  task automatic test_store_evict();
    int c;
    logic [31:0] d;
    int base;
    base = wa.size();
    @(negedge CLK);
    dmemWEN = 1'b1;
    dmemaddr = 32'h100;
    dmemstore = 32'hCAFEF00D;
    #1;
    total++; if ({dhit, dREN, dWEN} !== 3'b100) $display("FAIL store_hit got dhit=%b ren=%b wen=%b want 1 0 0", dhit, dREN, dWEN); else passed++;
    load(32'h140, c, d);
    total++; if (c !== 3 || d !== 32'hF0000140) $display("FAIL load_140 got cyc=%0d data=%h want 3 f0000140", c, d); else passed++;
    @(negedge CLK);
    dmemaddr = 32'h180;
    #1;
    total++; if (dhit !== 1'b0) $display("FAIL evict_miss got dhit=%b want 0", dhit); else passed++;
    @(negedge CLK); #1;
    total++; if ({dWEN, dREN, daddr, dstore} !== {2'b10, 32'h100, 32'hCAFEF00D}) $display("FAIL evict_wb0 got wen=%b ren=%b addr=%h data=%h want 1 0 00000100 cafef00d", dWEN, dREN, daddr, dstore); else passed++;
    @(negedge CLK); #1;
    total++; if ({dWEN, daddr, dstore} !== {1'b1, 32'h104, 32'hF0000104}) $display("FAIL evict_wb1 got wen=%b addr=%h data=%h want 1 00000104 f0000104", dWEN, daddr, dstore); else passed++;
    @(negedge CLK); #1;
    total++; if ({dREN, dWEN, daddr} !== {2'b10, 32'h180}) $display("FAIL evict_ld0 got ren=%b wen=%b addr=%h want 1 0 00000180", dREN, dWEN, daddr); else passed++;
    @(negedge CLK); #1;
    total++; if ({dREN, daddr} !== {1'b1, 32'h184}) $display("FAIL evict_ld1 got ren=%b addr=%h want 1 00000184", dREN, daddr); else passed++;
    @(negedge CLK); #1;
    total++; if ({dhit, dmemload} !== {1'b1, 32'hF0000180}) $display("FAIL evict_hit got dhit=%b load=%h want 1 f0000180", dhit, dmemload); else passed++;
    idle();
    total++; if (wa.size() - base !== 2 || mem[64] !== 32'hCAFEF00D) $display("FAIL evict_writes got count=%0d mem100=%h want 2 cafef00d", wa.size() - base, mem[64]); else passed++;
  endtask

  task automatic test_lru();
    int c;
    logic [31:0] d;
    load(32'h018, c, d);
    load(32'h058, c, d);
    total++; if (c !== 3 || d !== 32'hF0000058) $display("FAIL lru_fill got cyc=%0d data=%h want 3 f0000058", c, d); else passed++;
    load(32'h018, c, d);
    total++; if (c !== 0 || d !== 32'hF0000018) $display("FAIL lru_touch got cyc=%0d data=%h want 0 f0000018", c, d); else passed++;
    load(32'h098, c, d);
    total++; if (c !== 3 || d !== 32'hF0000098) $display("FAIL lru_evict got cyc=%0d data=%h want 3 f0000098", c, d); else passed++;
    load(32'h018, c, d);
    total++; if (c !== 0) $display("FAIL lru_kept_018 got cyc=%0d want 0", c); else passed++;
    load(32'h058, c, d);
    total++; if (c !== 3) $display("FAIL lru_replaced_058 got cyc=%0d want 3", c); else passed++;
    idle();
  endtask

  task automatic test_dwait_stretch();
    int bad;
    bad = 0;
    wait_n = 4;
    @(negedge CLK);
    dmemREN = 1'b1;
    dmemaddr = 32'h228;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      if (!dREN || dWEN || dhit || daddr !== (k < 5 ? 32'h228 : 32'h22C)) bad++;
    end
    total++; if (bad !== 0) $display("FAIL stretch_hold got %0d bad cycles want 0", bad); else passed++;
    @(negedge CLK); #1;
    total++; if ({dhit, dmemload} !== {1'b1, 32'hF0000228}) $display("FAIL stretch_hit got dhit=%b load=%h want 1 f0000228", dhit, dmemload); else passed++;
    dmemaddr = 32'h22C;
    #1;
    total++; if ({dhit, dmemload} !== {1'b1, 32'hF000022C}) $display("FAIL stretch_word1 got dhit=%b load=%h want 1 f000022c", dhit, dmemload); else passed++;
    idle();
    wait_n = 0;
  endtask

  task automatic test_halt_flush();
    int c;
    int base;
    int cyc;
    logic [31:0] ea [6];
    logic [31:0] ed [6];
    ea = '{32'h140, 32'h144, 32'h010, 32'h014, 32'h038, 32'h03C};
    ed = '{32'hA0A0A0A0, 32'hF0000144, 32'hF0000010, 32'hB2B2B2B2, 32'hF0000038, 32'hC7C7C7C7};
    store(32'h140, 32'hA0A0A0A0, c);
    total++; if (c !== 0) $display("FAIL flush_store_hit got cyc=%0d want 0", c); else passed++;
    store(32'h014, 32'hB2B2B2B2, c);
    total++; if (c !== 3) $display("FAIL flush_store_alloc got cyc=%0d want 3", c); else passed++;
    store(32'h03C, 32'hC7C7C7C7, c);
    idle();
    base = wa.size();
    halt = 1'b1;
    cyc = 0;
    #1;
    while (!flushed && cyc < 200) begin
      @(negedge CLK); #1;
      cyc++;
    end
    total++; if (flushed !== 1'b1) $display("FAIL flush_done got flushed=%b after %0d cycles want 1", flushed, cyc); else passed++;
    total++; if (wa.size() - base !== 6) $display("FAIL flush_count got %0d writes want 6", wa.size() - base); else passed++;
    for (int k = 0; k < 6; k++)
      if (base + k < wa.size()) begin
        total++; if (wa[base+k] !== ea[k] || wd[base+k] !== ed[k]) $display("FAIL flush_write%0d got %h/%h want %h/%h", k, wa[base+k], wd[base+k], ea[k], ed[k]); else passed++;
      end
    @(negedge CLK);
    halt = 1'b0;
    dmemREN = 1'b1;
    dmemaddr = 32'h018;
    repeat (3) @(negedge CLK);
    #1;
    total++; if ({flushed, dhit, dREN, dWEN} !== 4'b1000) $display("FAIL flush_sticky got fl=%b dhit=%b ren=%b wen=%b want 1 0 0 0", flushed, dhit, dREN, dWEN); else passed++;
    idle();
  endtask

  task automatic test_reset_mid_refill();
    int c;
    logic [31:0] d;
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    dmemREN = 1'b1;
    dmemaddr = 32'h300;
    @(negedge CLK); #1;
    total++; if ({dREN, daddr} !== {1'b1, 32'h300}) $display("FAIL mid_ld0 got ren=%b addr=%h want 1 00000300", dREN, daddr); else passed++;
    @(negedge CLK); #1;
    total++; if ({dREN, daddr} !== {1'b1, 32'h304}) $display("FAIL mid_ld1 got ren=%b addr=%h want 1 00000304", dREN, daddr); else passed++;
    nRST = 1'b0;
    #1;
    total++; if ({dhit, dmemload, flushed, dREN, dWEN, daddr, dstore} !== '0) $display("FAIL mid_reset_outputs got dhit=%b load=%h fl=%b ren=%b wen=%b addr=%h st=%h want all 0", dhit, dmemload, flushed, dREN, dWEN, daddr, dstore); else passed++;
    @(negedge CLK);
    dmemREN = 1'b0;
    nRST = 1'b1;
    load(32'h300, c, d);
    total++; if (c !== 3 || d !== 32'hF0000300) $display("FAIL mid_retry got cyc=%0d data=%h want 3 f0000300", c, d); else passed++;
    idle();
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_evict();
    test_lru();
    test_dwait_stretch();
    test_halt_flush();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
